// File: rtl/booth_wallace_mul_pipe.sv
// ---------------------------------------------------------------------------
// booth_wallace_mul_pipe
//
// Pipelined radix-4 Booth multiplier with a 3:2 compressor tree. It is used
// in the mantissa path of the Posit FMAU. The result is given both resolved
// (prod) and in carry-save form (cs_sum/cs_carry), so a downstream fused adder
// can skip the final carry-propagate add.
//
// Pipeline:
//   S1  Booth encoding and partial-product selection (rows + increment bits)
//   S2  CSA tree reduction to a sum/carry pair
//   S3  carry-propagate add; the S2 pair is also forwarded to the outputs
// An operand beat appears on the outputs three clock edges after it is
// captured. The edge that captures it counts as the first of the three.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   in_valid  operand beat valid
//   in_ready  stage 1 can accept a beat (combinational from stage state)
//   a, b      multiplicand / multiplier, WIDTH bits
//   tc        1: operands are two's complement, 0: unsigned
//   in_tag    sideband tag, returned unchanged with the result
//   out_valid result valid
//   out_ready consumer accepts the result
//   prod      exact 2*WIDTH-bit product
//   cs_sum    carry-save sum vector
//   cs_carry  carry-save carry vector; cs_sum + cs_carry == prod (mod 2^(2W))
//   out_tag   tag of the current result
// ---------------------------------------------------------------------------
module booth_wallace_mul_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [2*WIDTH-1:0] cs_sum,
    output logic [2*WIDTH-1:0] cs_carry,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int E    = WIDTH + 2;     // extended operand width
    localparam int NPP  = WIDTH / 2 + 1; // number of Booth digits / PP rows
    localparam int L    = E + 1;         // PP row width (holds +/-2*a)
    localparam int P    = 2 * WIDTH;     // product width
    localparam int NOPS = NPP + 2;       // rows + increment vector + constant

    // Each row has its sign bit s replaced by ~s. That equals the true signed
    // row plus 2^(L-1). This constant removes all those offsets at once, so
    // no row needs full-width sign extension.
    function automatic logic [P-1:0] sext_const();
        logic [P-1:0] c;
        c = '0;
        for (int i = 0; i < NPP; i++) begin
            c = c - (P'(1) << (L - 1 + 2 * i));
        end
        return c;
    endfunction

    localparam logic [P-1:0] SEXT_C = sext_const();

    // Booth recoding of one digit. Returns {increment bit, row}. A negative
    // digit gives the one's complement, and the increment bit finishes the
    // negation. The sign bit of the row is already inverted.
    function automatic logic [L:0] booth_pp(input logic [2:0] trip,
                                            input logic [E-1:0] ae);
        logic [L-1:0] mag;
        logic [L-1:0] r;
        logic         neg;
        case (trip)
            3'b001, 3'b010, 3'b101, 3'b110: mag = {ae[E-1], ae};
            3'b011, 3'b100:                 mag = {ae, 1'b0};
            default:                        mag = '0;
        endcase
        neg = trip[2] & ~(trip[1] & trip[0]);
        r   = neg ? ~mag : mag;
        return {neg, ~r[L-1], r[L-2:0]};
    endfunction

    // Wallace-style reduction. Each level groups the operands into 3:2
    // compressors and passes leftovers through, until two vectors remain.
    function automatic logic [2*P-1:0] csa_reduce(input logic [NOPS*P-1:0] ops);
        logic [P-1:0] v  [NOPS];
        logic [P-1:0] nv [NOPS];
        logic [P-1:0] x, y, z;
        int n, m, t;
        for (int i = 0; i < NOPS; i++) begin
            v[i] = ops[i*P +: P];
        end
        n = NOPS;
        for (int lvl = 0; lvl < NOPS; lvl++) begin
            if (n > 2) begin
                for (int j = 0; j < NOPS; j++) begin
                    nv[j] = '0;
                end
                t = n / 3;
                for (int j = 0; j < NOPS / 3; j++) begin
                    if (j < t) begin
                        x = v[3*j];
                        y = v[3*j+1];
                        z = v[3*j+2];
                        nv[2*j]   = x ^ y ^ z;
                        nv[2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
                    end
                end
                m = 2 * t;
                for (int j = 0; j < NOPS; j++) begin
                    if (j >= 3 * t && j < n) begin
                        nv[m] = v[j];
                        m     = m + 1;
                    end
                end
                n = m;
                for (int j = 0; j < NOPS; j++) begin
                    v[j] = nv[j];
                end
            end
        end
        return {v[0], v[1]};
    endfunction

    // Flow control
    logic r_vld_p1, r_vld_p2, r_vld_p3;
    logic w_rdy_p1, w_rdy_p2, w_rdy_p3;

    assign w_rdy_p3 = !r_vld_p3 || out_ready;
    assign w_rdy_p2 = !r_vld_p2 || w_rdy_p3;
    assign w_rdy_p1 = !r_vld_p1 || w_rdy_p2;
    assign in_ready = w_rdy_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            if (w_rdy_p1) r_vld_p1 <= in_valid;
            if (w_rdy_p2) r_vld_p2 <= r_vld_p1;
            if (w_rdy_p3) r_vld_p3 <= r_vld_p2;
        end
    end

    // ---- S1: Booth encode and select partial products ----
    logic [E-1:0]          w_a_ext;
    logic [E:0]            w_b_pad;   // extended b with the implicit b[-1]=0
    logic [NPP-1:0][L-1:0] w_row;
    logic [NPP-1:0]        w_inc;

    assign w_a_ext = {{2{tc & a[WIDTH-1]}}, a};
    assign w_b_pad = {{2{tc & b[WIDTH-1]}}, b, 1'b0};

    always_comb begin
        w_row = '0;
        w_inc = '0;
        for (int i = 0; i < NPP; i++) begin
            {w_inc[i], w_row[i]} = booth_pp(w_b_pad[2*i +: 3], w_a_ext);
        end
    end

    logic [NPP-1:0][L-1:0] r_row_p1;
    logic [NPP-1:0]        r_inc_p1;
    logic [TAG_W-1:0]      r_tag_p1;

    always_ff @(posedge clk) begin
        if (in_valid && w_rdy_p1) begin
            r_row_p1 <= w_row;
            r_inc_p1 <= w_inc;
            r_tag_p1 <= in_tag;
        end
    end

    // ---- S2: compress rows, increments and constant to a sum/carry pair ----
    logic [NOPS*P-1:0] w_ops;
    logic [P-1:0]      w_incv;
    logic [P-1:0]      w_sum, w_carry;

    always_comb begin
        w_ops  = '0;
        w_incv = '0;
        for (int i = 0; i < NPP; i++) begin
            w_ops[i*P +: P] = P'(r_row_p1[i]) << (2 * i);
            w_incv[2*i]     = r_inc_p1[i];
        end
        w_ops[NPP*P +: P]     = w_incv;
        w_ops[(NPP+1)*P +: P] = SEXT_C;
    end

    assign {w_sum, w_carry} = csa_reduce(w_ops);

    logic [P-1:0]     r_sum_p2, r_carry_p2;
    logic [TAG_W-1:0] r_tag_p2;

    always_ff @(posedge clk) begin
        if (r_vld_p1 && w_rdy_p2) begin
            r_sum_p2   <= w_sum;
            r_carry_p2 <= w_carry;
            r_tag_p2   <= r_tag_p1;
        end
    end

    // ---- S3: carry-propagate add and output registers ----
    logic [P-1:0]     r_prod_p3, r_sum_p3, r_carry_p3;
    logic [TAG_W-1:0] r_tag_p3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod_p3  <= '0;
            r_sum_p3   <= '0;
            r_carry_p3 <= '0;
            r_tag_p3   <= '0;
        end else if (r_vld_p2 && w_rdy_p3) begin
            r_prod_p3  <= r_sum_p2 + r_carry_p2;
            r_sum_p3   <= r_sum_p2;
            r_carry_p3 <= r_carry_p2;
            r_tag_p3   <= r_tag_p2;
        end
    end

    assign out_valid = r_vld_p3;
    assign prod      = r_prod_p3;
    assign cs_sum    = r_sum_p3;
    assign cs_carry  = r_carry_p3;
    assign out_tag   = r_tag_p3;

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Testbench for booth_wallace_mul_pipe: directed table vectors, pipeline
// streaming / back-pressure / reset sequences at WIDTH=8, and random streams
// at WIDTH=8 and WIDTH=32 checked against an arithmetic reference.
module tb_booth_wallace_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=8 instance
    logic        in_valid, in_ready, tc, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] prod, cs_sum, cs_carry;

    // WIDTH=32 instance
    logic        in_valid_w, in_ready_w, tc_w, out_valid_w, out_ready_w;
    logic [31:0] a_w, b_w;
    logic [3:0]  in_tag_w, out_tag_w;
    logic [63:0] prod_w, cs_sum_w, cs_carry_w;

    booth_wallace_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tc(tc), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .prod(prod), .cs_sum(cs_sum),
        .cs_carry(cs_carry), .out_tag(out_tag)
    );

    booth_wallace_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .tc(tc_w), .in_tag(in_tag_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .prod(prod_w), .cs_sum(cs_sum_w),
        .cs_carry(cs_carry_w), .out_tag(out_tag_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product of w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input int w, input logic t);
        logic [63:0] xa, ya, p, m;
        xa = 64'(x);
        ya = 64'(y);
        if (t && x[w-1]) xa = xa | (~64'd0 << w);
        if (t && y[w-1]) ya = ya | (~64'd0 << w);
        p = xa * ya;
        m = (w == 32) ? ~64'd0 : ((64'd1 << (2 * w)) - 64'd1);
        return p & m;
    endfunction

    // Scoreboards: push on accept, pop and compare on consume.
    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    exp_t e8, e32;
    logic mon8_en  = 1'b0;
    logic mon32_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
        end else if (mon8_en) begin
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected_out8", 64'(out_valid), 64'd0);
                end else begin
                    e8 = q8.pop_front();
                    check("sb_prod8", 64'(prod), e8.prod);
                    check("sb_cs8", 64'(16'(cs_sum + cs_carry)), e8.prod);
                    check("sb_tag8", 64'(out_tag), 64'(e8.tag));
                end
            end
            if (in_valid && in_ready) q8.push_back('{ref_mul(32'(a), 32'(b), 8, tc), in_tag});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
        end else if (mon32_en) begin
            if (out_valid_w && out_ready_w) begin
                if (q32.size() == 0) begin
                    check("unexpected_out32", 64'(out_valid_w), 64'd0);
                end else begin
                    e32 = q32.pop_front();
                    check("sb_prod32", prod_w, e32.prod);
                    check("sb_cs32", cs_sum_w + cs_carry_w, e32.prod);
                    check("sb_tag32", 64'(out_tag_w), 64'(e32.tag));
                end
            end
            if (in_valid_w && in_ready_w) q32.push_back('{ref_mul(a_w, b_w, 32, tc_w), in_tag_w});
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        tc;
        logic [3:0]  tag;
        logic [15:0] prod;
    } vec_t;

    vec_t        tbl [12];
    logic [15:0] held;

    initial begin
        int k;

        tbl[0]  = '{8'h80, 8'h80, 1'b1, 4'd3,  16'h4000};
        tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 4'd1,  16'hFE01};
        tbl[2]  = '{8'hFF, 8'hFF, 1'b1, 4'd2,  16'h0001};
        tbl[3]  = '{8'hFF, 8'h01, 1'b1, 4'd4,  16'hFFFF};
        tbl[4]  = '{8'h00, 8'h5A, 1'b0, 4'd5,  16'h0000};
        tbl[5]  = '{8'h10, 8'h10, 1'b0, 4'd6,  16'h0100};
        tbl[6]  = '{8'h7F, 8'h80, 1'b1, 4'd7,  16'hC080};
        tbl[7]  = '{8'h80, 8'h80, 1'b0, 4'd8,  16'h4000};
        tbl[8]  = '{8'h7F, 8'h7F, 1'b1, 4'd9,  16'h3F01};
        tbl[9]  = '{8'h0C, 8'h0D, 1'b0, 4'd10, 16'h009C};
        tbl[10] = '{8'hFE, 8'h03, 1'b1, 4'd11, 16'hFFFA};
        tbl[11] = '{8'hFF, 8'h01, 1'b0, 4'd12, 16'h00FF};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; tc = 1'b0; in_tag = '0; out_ready = 1'b1;
        in_valid_w = 1'b0; a_w = '0; b_w = '0; tc_w = 1'b0; in_tag_w = '0; out_ready_w = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", 64'(prod), 64'd0);
        check("rst_cs_sum", 64'(cs_sum), 64'd0);
        check("rst_cs_carry", 64'(cs_carry), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table, one op at a time, with latency checks
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; tc = tbl[i].tc; in_tag = tbl[i].tag;
            #1;
            check("tbl_in_ready", 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            check("tbl_lat1", 64'(out_valid), 64'd0);
            step();
            check("tbl_lat2", 64'(out_valid), 64'd0);
            step();
            check("tbl_out_valid", 64'(out_valid), 64'd1);
            check("tbl_prod", 64'(prod), 64'(tbl[i].prod));
            check("tbl_cs", 64'(16'(cs_sum + cs_carry)), 64'(tbl[i].prod));
            check("tbl_tag", 64'(out_tag), 64'(tbl[i].tag));
            step();
        end

        // Back-to-back stream of 8 beats
        mon8_en = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            if (p < 8) begin
                in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
                tc = p[0]; in_tag = 4'(p);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (p < 8) check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_out_valid", 64'(out_valid), 64'(p >= 3 && p <= 10));
            step();
        end

        // Fill with out_ready=0, then release
        out_ready = 1'b0;
        k = 0;
        for (int p = 0; p < 11; p++) begin
            if (p == 6) out_ready = 1'b1;
            if (k < 4) begin
                in_valid = 1'b1; a = tbl[k].a; b = tbl[k].b; tc = tbl[k].tc; in_tag = 4'(8 + k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (p <= 6) check("fill_in_ready", 64'(in_ready), 64'(p < 3 || p == 6));
            check("fill_out_valid", 64'(out_valid), 64'(p >= 3 && p <= 9));
            if (p == 3) held = prod;
            if (p == 5) check("fill_hold_prod", 64'(prod), 64'(held));
            if (in_valid && in_ready) k++;
            step();
        end
        check("fill_accepts", 64'(k), 64'd4);

        // Reset with two ops in flight
        in_valid = 1'b1; a = 8'h12; b = 8'h34; tc = 1'b0; in_tag = 4'd1;
        step();
        a = 8'h56; b = 8'h78; in_tag = 4'd2;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("inrst_out_valid", 64'(out_valid), 64'd0);
        check("inrst_prod", 64'(prod), 64'd0);
        check("inrst_cs_sum", 64'(cs_sum), 64'd0);
        check("inrst_cs_carry", 64'(cs_carry), 64'd0);
        check("inrst_in_ready", 64'(in_ready), 64'd1);
        for (int p = 0; p < 4; p++) begin
            step();
            check("inrst_no_stale", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1; a = tbl[6].a; b = tbl[6].b; tc = tbl[6].tc; in_tag = tbl[6].tag;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("postrst_out_valid", 64'(out_valid), 64'd1);
        check("postrst_prod", 64'(prod), 64'(tbl[6].prod));
        check("postrst_tag", 64'(out_tag), 64'(tbl[6].tag));
        step();

        // Random stream with random back-pressure, WIDTH=8
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom); in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        check("rand8_drained", 64'(q8.size()), 64'd0);

        // Random stream with random back-pressure, WIDTH=32
        mon32_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            in_valid_w  = ($urandom_range(0, 3) != 0);
            a_w = $urandom; b_w = $urandom; tc_w = 1'($urandom); in_tag_w = 4'($urandom);
            out_ready_w = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid_w = 1'b0; out_ready_w = 1'b1;
        repeat (6) step();
        check("rand32_drained", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
